// File: rtl/btn_debounce_multi_if.sv
// Button conditioner bundle: raw buttons in, debounced level and event pulses out.
// The master drives the raw buttons; the conditioner is the slave.
interface btn_debounce_multi_if #(
    parameter int NUM_BTN = 5
);
    logic [NUM_BTN-1:0] i_btn;
    logic [NUM_BTN-1:0] o_level;
    logic [NUM_BTN-1:0] o_press;
    logic [NUM_BTN-1:0] o_release;
    logic [NUM_BTN-1:0] o_long;

    modport master (
        output i_btn,
        input  o_level, o_press, o_release, o_long
    );

    modport slave (
        input  i_btn,
        output o_level, o_press, o_release, o_long
    );
endinterface

// File: rtl/btn_debounce_multi.sv
// N-channel button conditioner: synchroniser, debounce, press/release/long pulses.
// Define BTN_AUTO_REPEAT_EN to add auto-repeat presses while a button is in LONG.
module btn_debounce_multi #(
    parameter int NUM_BTN       = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 1000000,
    parameter int LONG_CYCLES   = 100000000,
    parameter int REPEAT_CYCLES = 20000000
) (
    input logic                  clk,
    input logic                  reset,
    btn_debounce_multi_if.slave  btn_if
);
    localparam int DW = $clog2(DB_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DB_CYCLES < 2 ||
        LONG_CYCLES <= DB_CYCLES || REPEAT_CYCLES < 1) begin : g_cfg_err
        $error("btn_debounce_multi: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_e;

    state_e                 state_q [NUM_BTN];
    state_e                 state_d [NUM_BTN];
    logic [SYNC_STAGES-1:0] sync_q  [NUM_BTN];
    logic [SYNC_STAGES-1:0] sync_d  [NUM_BTN];
    logic [DW-1:0]          db_q    [NUM_BTN];
    logic [DW-1:0]          db_d    [NUM_BTN];
    logic [HW-1:0]          hold_q  [NUM_BTN];
    logic [HW-1:0]          hold_d  [NUM_BTN];
    logic [NUM_BTN-1:0]     level_q, level_d;
    logic [NUM_BTN-1:0]     press_q, press_d;
    logic [NUM_BTN-1:0]     rel_q, rel_d;
    logic [NUM_BTN-1:0]     long_q, long_d;
    logic [NUM_BTN-1:0]     sync_b, rise, fall;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_q [NUM_BTN];
    logic [RW-1:0] rep_d [NUM_BTN];
`endif

    always_comb begin
        sync_b  = '0;
        rise    = '0;
        fall    = '0;
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        long_d  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            sync_d[i]  = {sync_q[i][SYNC_STAGES-2:0], btn_if.i_btn[i]};
            sync_b[i]  = sync_q[i][SYNC_STAGES-1];
            db_d[i]    = '0;
            hold_d[i]  = '0;
            state_d[i] = state_q[i];
`ifdef BTN_AUTO_REPEAT_EN
            rep_d[i]   = '0;
`endif
            // any cycle back at the stable level restarts the count
            if (sync_b[i] != level_q[i]) begin
                if (db_q[i] == DB_LAST) begin
                    level_d[i] = sync_b[i];
                end else begin
                    db_d[i] = db_q[i] + 1'b1;
                end
            end
            rise[i]    = level_d[i] & ~level_q[i];
            fall[i]    = ~level_d[i] & level_q[i];
            press_d[i] = rise[i];
            rel_d[i]   = fall[i];
            if (level_q[i] && !fall[i]) begin
                hold_d[i] = (hold_q[i] == LONG_MAX) ? hold_q[i]
                                                     : hold_q[i] + 1'b1;
            end
            case (state_q[i])
                IDLE: begin
                    if (rise[i]) state_d[i] = PRESSED;
                end
                PRESSED: begin
                    if (fall[i]) begin
                        state_d[i] = IDLE;
                    end else if (hold_q[i] == LONG_LAST) begin
                        state_d[i] = LONG;
                        long_d[i]  = 1'b1;
                    end
                end
                LONG: begin
                    if (fall[i]) begin
                        state_d[i] = IDLE;
                    end else begin
`ifdef BTN_AUTO_REPEAT_EN
                        if (rep_q[i] == REP_LAST) begin
                            press_d[i] = 1'b1;
                        end else begin
                            rep_d[i] = rep_q[i] + 1'b1;
                        end
`endif
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            long_q  <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= IDLE;
                sync_q[i]  <= '0;
                db_q[i]    <= '0;
                hold_q[i]  <= '0;
`ifdef BTN_AUTO_REPEAT_EN
                rep_q[i]   <= '0;
`endif
            end
        end else begin
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                sync_q[i]  <= sync_d[i];
                db_q[i]    <= db_d[i];
                hold_q[i]  <= hold_d[i];
`ifdef BTN_AUTO_REPEAT_EN
                rep_q[i]   <= rep_d[i];
`endif
            end
        end
    end

    assign btn_if.o_level   = level_q;
    assign btn_if.o_press   = press_q;
    assign btn_if.o_release = rel_q;
    assign btn_if.o_long    = long_q;
endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: vector table plus hand-written
// hold, reset and auto-repeat sequences.
module tb_btn_debounce_multi;
    localparam int NB = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    btn_debounce_multi_if #(.NUM_BTN(NB)) bif ();

    btn_debounce_multi #(
        .NUM_BTN(NB),
        .SYNC_STAGES(2),
        .DB_CYCLES(4),
        .LONG_CYCLES(20),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_if(bif)
    );

    typedef struct {
        logic [NB-1:0] btn;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rls;
        logic [NB-1:0] lng;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        bif.i_btn = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int pe, le, re, np, nl, nr;
    int pe1;
    int early;
    int pq[$];

    initial begin
        bif.i_btn = '0;
        #1;
        chk("rst_level", 32'(bif.o_level), 0);
        chk("rst_press", 32'(bif.o_press), 0);
        chk("rst_release", 32'(bif.o_release), 0);
        chk("rst_long", 32'(bif.o_long), 0);

        // ch0 clean press/release, ch1 bounce, ch2 2-cycle glitch, ch3 idle
        for (int v = 0; v < NV; v++) begin
            tbl[v].btn    = '0;
            tbl[v].btn[0] = (v < 12);
            tbl[v].btn[1] = (v == 0 || v == 2 || v >= 4) && v < 20;
            tbl[v].btn[2] = (v == 2 || v == 3);
            tbl[v].lvl    = '0;
            tbl[v].lvl[0] = (v >= 5 && v < 17);
            tbl[v].lvl[1] = (v >= 9 && v < 25);
            tbl[v].prs    = '0;
            tbl[v].prs[0] = (v == 5);
            tbl[v].prs[1] = (v == 9);
            tbl[v].rls    = '0;
            tbl[v].rls[0] = (v == 17);
            tbl[v].rls[1] = (v == 25);
            tbl[v].lng    = '0;
        end

        do_reset();
        for (int v = 0; v < NV; v++) begin
            bif.i_btn = tbl[v].btn;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_level", v), 32'(bif.o_level), 32'(tbl[v].lvl));
            chk($sformatf("v%0d_press", v), 32'(bif.o_press), 32'(tbl[v].prs));
            chk($sformatf("v%0d_release", v), 32'(bif.o_release), 32'(tbl[v].rls));
            chk($sformatf("v%0d_long", v), 32'(bif.o_long), 32'(tbl[v].lng));
            @(negedge clk);
        end

        // ch3 long hold: input high for edges 1..35
        do_reset();
        pe = -1; le = -1; re = -1; np = 0; nl = 0; nr = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            bif.i_btn[3] = (k <= 35);
            @(posedge clk);
            #1;
            if (bif.o_press[3]) begin np++; if (pe < 0) pe = k; end
            if (bif.o_long[3]) begin nl++; if (le < 0) le = k; end
            if (bif.o_release[3]) begin nr++; if (re < 0) re = k; end
        end
        chk("hold_press_edge", 32'(pe), 6);
        chk("hold_long_edge", 32'(le), 26);
        chk("hold_long_count", 32'(nl), 1);
        chk("hold_release_edge", 32'(re), 41);
        chk("hold_release_count", 32'(nr), 1);
`ifdef BTN_AUTO_REPEAT_EN
        chk("hold_press_count", 32'(np), 2);
`else
        chk("hold_press_count", 32'(np), 1);
`endif

        // reset while ch0 PRESSED and ch1 mid-debounce
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bif.i_btn[0] = 1'b1;
            if (k == 9) bif.i_btn[1] = 1'b1;
            @(posedge clk);
        end
        #1;
        chk("pre_rst_level", 32'(bif.o_level), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_level", 32'(bif.o_level), 0);
        chk("mid_rst_pulses",
            32'(bif.o_press | bif.o_release | bif.o_long), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pe = -1; pe1 = -1; early = 0; nr = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (bif.o_press[0] && pe < 0) pe = k;
            if (bif.o_press[1] && pe1 < 0) pe1 = k;
            if (k < 6 && (bif.o_press | bif.o_long | bif.o_level) != 0) early++;
            if (bif.o_release != 0) nr++;
        end
        chk("post_rst_press0_edge", 32'(pe), 6);
        chk("post_rst_press1_edge", 32'(pe1), 6);
        chk("post_rst_early_pulse", 32'(early), 0);
        chk("post_rst_release", 32'(nr), 0);

`ifdef BTN_AUTO_REPEAT_EN
        // ch0 held 45 cycles past press: long +20, repeats +28/+36/+44
        do_reset();
        pq.delete();
        le = -1; nr = 0; re = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            bif.i_btn[0] = (k <= 50);
            @(posedge clk);
            #1;
            if (bif.o_press[0]) pq.push_back(k);
            if (bif.o_long[0] && le < 0) le = k;
            if (bif.o_release[0]) begin nr++; if (re < 0) re = k; end
        end
        chk("rep_count", 32'(pq.size()), 4);
        if (pq.size() == 4) begin
            chk("rep_press0", 32'(pq[0]), 6);
            chk("rep_press1", 32'(pq[1]), 34);
            chk("rep_press2", 32'(pq[2]), 42);
            chk("rep_press3", 32'(pq[3]), 50);
        end
        chk("rep_long_edge", 32'(le), 26);
        chk("rep_release_edge", 32'(re), 56);
        chk("rep_release_count", 32'(nr), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
